// File: rtl/tile_to_raster_if.sv
// Stream interface for tile_to_raster: tile-order pixels in, raster-order pixels out.
interface tile_to_raster_if #(
    parameter int unsigned PIX_WIDTH = 8
) ();
    logic                 iValid;
    logic [PIX_WIDTH-1:0] iData;
    logic                 oReady;
    logic                 oValid;
    logic [PIX_WIDTH-1:0] oData;
    logic                 oLine_end;
    logic                 oFrame_done;
    logic [10:0]          oTile_cnt;

    modport master (
        output iValid, iData,
        input  oReady, oValid, oData, oLine_end, oFrame_done, oTile_cnt
    );

    modport slave (
        input  iValid, iData,
        output oReady, oValid, oData, oLine_end, oFrame_done, oTile_cnt
    );
endinterface

// File: rtl/tile_to_raster.sv
// Captures a frame delivered tile by tile into a frame buffer at raster addresses,
// then streams the whole frame back out in raster order.
module tile_to_raster #(
    parameter int unsigned PIX_WIDTH   = 8,
    parameter int unsigned IMG_WIDTH   = 32,
    parameter int unsigned IMG_HEIGHT  = 16,
    parameter int unsigned TILE_WIDTH  = 16,
    parameter int unsigned TILE_HEIGHT = 16
) (
    input logic              iClk,
    input logic              iRst,
    tile_to_raster_if.slave  bus
);
    localparam int unsigned NUM_TILES_X = IMG_WIDTH / TILE_WIDTH;
    localparam int unsigned NUM_TILES_Y = IMG_HEIGHT / TILE_HEIGHT;
    localparam int unsigned DEPTH       = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned NW  = $clog2(DEPTH + 1);
    localparam int unsigned CW  = (TILE_WIDTH > 1) ? $clog2(TILE_WIDTH) : 1;
    localparam int unsigned RW  = (TILE_HEIGHT > 1) ? $clog2(TILE_HEIGHT) : 1;
    localparam int unsigned TXW = (NUM_TILES_X > 1) ? $clog2(NUM_TILES_X) : 1;
    localparam int unsigned TYW = (NUM_TILES_Y > 1) ? $clog2(NUM_TILES_Y) : 1;
    localparam int unsigned XW  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    typedef enum logic [0:0] {StFill, StDrain} state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        col_q, col_d;
    logic [RW-1:0]        row_q, row_d;
    logic [TXW-1:0]       tx_q, tx_d;
    logic [TYW-1:0]       ty_q, ty_d;
    logic [10:0]          tile_cnt_q, tile_cnt_d;
    logic [NW-1:0]        rd_cnt_q, rd_cnt_d;
    logic [XW-1:0]        rd_x_q, rd_x_d;
    logic                 valid_q, line_end_q, frame_done_q;
    logic [PIX_WIDTH-1:0] data_q;
    logic [PIX_WIDTH-1:0] mem_q [DEPTH];

    logic          accept, issue, drain_exit;
    logic          col_last, row_last, tx_last, ty_last, tile_done, last_pix;
    logic [AW-1:0] wr_addr, rd_addr;

    assign col_last  = (col_q == CW'(TILE_WIDTH - 1));
    assign row_last  = (row_q == RW'(TILE_HEIGHT - 1));
    assign tx_last   = (tx_q == TXW'(NUM_TILES_X - 1));
    assign ty_last   = (ty_q == TYW'(NUM_TILES_Y - 1));
    assign tile_done = accept && col_last && row_last;
    assign last_pix  = tile_done && tx_last && ty_last;

    assign wr_addr = AW'((32'(ty_q) * TILE_HEIGHT + 32'(row_q)) * IMG_WIDTH
                         + 32'(tx_q) * TILE_WIDTH + 32'(col_q));
    assign rd_addr = rd_cnt_q[AW-1:0];

    always_ff @(posedge iClk) begin
        if (!iRst) state_q <= StFill;
        else       state_q <= state_d;
    end

    // DRAIN lingers one cycle past the last issued address so its data is presented.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill:  if (last_pix) state_d = StDrain;
            StDrain: if (rd_cnt_q == NW'(DEPTH)) state_d = StFill;
            default: state_d = StFill;
        endcase
    end

    always_comb begin
        bus.oReady = (state_q == StFill);
        accept     = (state_q == StFill) && bus.iValid;
        issue      = (state_q == StDrain) && (rd_cnt_q != NW'(DEPTH));
        drain_exit = (state_q == StDrain) && (rd_cnt_q == NW'(DEPTH));
    end

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        tx_d       = tx_q;
        ty_d       = ty_q;
        tile_cnt_d = tile_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        rd_x_d     = rd_x_q;
        if (accept) begin
            col_d = col_last ? '0 : col_q + 1'b1;
            if (col_last) begin
                row_d = row_last ? '0 : row_q + 1'b1;
                if (row_last) begin
                    tx_d = tx_last ? '0 : tx_q + 1'b1;
                    if (tx_last) ty_d = ty_last ? '0 : ty_q + 1'b1;
                end
            end
        end
        if (drain_exit)     tile_cnt_d = '0;
        else if (tile_done) tile_cnt_d = tile_cnt_q + 11'd1;
        if (issue) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            rd_x_d   = (rd_x_q == XW'(IMG_WIDTH - 1)) ? '0 : rd_x_q + 1'b1;
        end else if (drain_exit) begin
            rd_cnt_d = '0;
            rd_x_d   = '0;
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst) begin
            col_q        <= '0;
            row_q        <= '0;
            tx_q         <= '0;
            ty_q         <= '0;
            tile_cnt_q   <= '0;
            rd_cnt_q     <= '0;
            rd_x_q       <= '0;
            valid_q      <= 1'b0;
            line_end_q   <= 1'b0;
            frame_done_q <= 1'b0;
            data_q       <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            tx_q         <= tx_d;
            ty_q         <= ty_d;
            tile_cnt_q   <= tile_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_x_q       <= rd_x_d;
            valid_q      <= issue;
            line_end_q   <= issue && (rd_x_q == XW'(IMG_WIDTH - 1));
            frame_done_q <= issue && (rd_cnt_q == NW'(DEPTH - 1));
            if (issue) data_q <= mem_q[rd_addr];
        end
    end

    // Frame buffer is intentionally not reset.
    always_ff @(posedge iClk) begin
        if (accept) mem_q[wr_addr] <= bus.iData;
    end

    assign bus.oValid      = valid_q;
    assign bus.oData       = data_q;
    assign bus.oLine_end   = line_end_q;
    assign bus.oFrame_done = frame_done_q;
    assign bus.oTile_cnt   = tile_cnt_q;
endmodule

// File: tb/tb_tile_to_raster.sv
// Directed/randomized bench for tile_to_raster with a raster-image reference model.
module tb_tile_to_raster;
    localparam int unsigned PW  = 8;
    localparam int unsigned W   = 32;
    localparam int unsigned H   = 16;
    localparam int unsigned TW  = 16;
    localparam int unsigned TH  = 16;
    localparam int unsigned D   = W * H;
    localparam int unsigned NTX = W / TW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tile_to_raster_if #(.PIX_WIDTH(PW)) bus ();

    tile_to_raster #(
        .PIX_WIDTH  (PW),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .TILE_WIDTH (TW),
        .TILE_HEIGHT(TH)
    ) dut (
        .iClk(clk),
        .iRst(rst_n),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [PW-1:0] oq_d [$];
    bit            oq_le [$];
    bit            oq_fd [$];
    int            oq_cyc [$];

    always @(negedge clk) begin
        if (bus.oValid === 1'b1) begin
            oq_d.push_back(bus.oData);
            oq_le.push_back(bus.oLine_end);
            oq_fd.push_back(bus.oFrame_done);
            oq_cyc.push_back(cyc);
        end
    end

    int total = 0;
    int bad = 0;
    int last_acc = 0;
    int first_acc = 0;
    logic [PW-1:0] img [D];
    logic [PW-1:0] exp_a [D];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Raster address of the k-th pixel in tile-arrival order.
    function automatic int tile_addr(input int k);
        int t, p;
        t = k / (TW * TH);
        p = k % (TW * TH);
        return ((t / NTX) * TH + p / TW) * W + (t % NTX) * TW + p % TW;
    endfunction

    task automatic clear_q();
        oq_d.delete();
        oq_le.delete();
        oq_fd.delete();
        oq_cyc.delete();
    endtask

    task automatic send_frame(input bit gap, input int npix, input bit tcheck);
        for (int k = 0; k < npix; k++) begin
            int g = 0;
            while (bus.oReady !== 1'b1 && g < 3000) begin
                @(posedge clk);
                #1;
                g++;
            end
            if (bus.oReady !== 1'b1) check("ready_timeout", 32'(bus.oReady), 32'd1);
            bus.iValid = 1'b1;
            bus.iData  = img[tile_addr(k)];
            if (k == 0) first_acc = cyc;
            last_acc = cyc;
            @(posedge clk);
            #1;
            if (tcheck && k == 255) check("tile_cnt_256", 32'(bus.oTile_cnt), 32'd1);
            if (tcheck && k == 511) check("tile_cnt_512", 32'(bus.oTile_cnt), 32'd2);
            if (gap) begin
                bus.iValid = 1'b0;
                bus.iData  = PW'($urandom);
                @(posedge clk);
                #1;
            end
        end
        bus.iValid = 1'b0;
    endtask

    task automatic wait_outs(input int n);
        for (int i = 0; i < 4000 && oq_d.size() < n; i++) @(posedge clk);
        #1;
        if (oq_d.size() < n) check("out_timeout", 32'(oq_d.size()), 32'(n));
    endtask

    task automatic check_frame(input string tag, input int off, input logic [PW-1:0] expv [D]);
        if (oq_d.size() < off + D) begin
            check({tag, "_count"}, 32'(oq_d.size()), 32'(off + D));
            return;
        end
        for (int i = 0; i < D; i++) begin
            check($sformatf("%s_data[%0d]", tag, i), 32'(oq_d[off+i]), 32'(expv[i]));
            check($sformatf("%s_le[%0d]", tag, i), 32'(oq_le[off+i]), 32'((i % W) == W - 1));
            check($sformatf("%s_fd[%0d]", tag, i), 32'(oq_fd[off+i]), 32'(i == D - 1));
        end
        check({tag, "_contig"}, 32'(oq_cyc[off+D-1] - oq_cyc[off]), 32'(D - 1));
    endtask

    task automatic rand_img();
        for (int i = 0; i < D; i++) img[i] = PW'($urandom);
    endtask

    initial begin
        int n, sz, nfd;
        bus.iValid = 1'b0;
        bus.iData  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(bus.oReady), 32'd1);
        check("rst_valid", 32'(bus.oValid), 32'd0);
        check("rst_data", 32'(bus.oData), 32'd0);
        check("rst_le", 32'(bus.oLine_end), 32'd0);
        check("rst_fd", 32'(bus.oFrame_done), 32'd0);
        check("rst_tiles", 32'(bus.oTile_cnt), 32'd0);
        @(posedge clk);
        #1;

        // Continuous fill, pixel value = raster address mod 256.
        for (int i = 0; i < D; i++) img[i] = PW'(i % 256);
        clear_q();
        send_frame(1'b0, D, 1'b0);
        check("ready_drop", 32'(bus.oReady), 32'd0);
        wait_outs(D);
        repeat (5) @(posedge clk);
        #1;
        check("cont_count", 32'(oq_d.size()), 32'(D));
        if (oq_cyc.size() > 0) check("turnaround", 32'(oq_cyc[0] - last_acc), 32'd2);
        check_frame("cont", 0, img);

        // Gapped input: iValid toggles, junk data on idle cycles.
        rand_img();
        clear_q();
        send_frame(1'b1, D, 1'b1);
        wait_outs(D);
        check_frame("gap", 0, img);

        // Junk held valid during drain must be refused and leave the frame intact.
        rand_img();
        clear_q();
        send_frame(1'b0, D, 1'b0);
        bus.iValid = 1'b1;
        bus.iData  = 8'hFF;
        n = 0;
        while (bus.oReady !== 1'b1 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus.iValid = 1'b0;
        check("drain_ready_low", 32'(n), 32'(D + 1));
        wait_outs(D);
        check_frame("junk", 0, img);

        // Back-to-back frames A then B.
        rand_img();
        exp_a = img;
        clear_q();
        send_frame(1'b0, D, 1'b0);
        rand_img();
        send_frame(1'b0, D, 1'b0);
        if (oq_cyc.size() >= D) check("b2b_gap", 32'(first_acc - oq_cyc[D-1]), 32'd1);
        wait_outs(2 * D);
        check_frame("frameA", 0, exp_a);
        check_frame("frameB", D, img);

        // Reset after 300 input pixels.
        rand_img();
        clear_q();
        send_frame(1'b0, 300, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstfill_ready", 32'(bus.oReady), 32'd1);
        check("rstfill_tiles", 32'(bus.oTile_cnt), 32'd0);
        check("rstfill_valid", 32'(bus.oValid), 32'd0);
        @(posedge clk);
        #1;
        rand_img();
        send_frame(1'b0, D, 1'b0);
        wait_outs(D);
        repeat (10) @(posedge clk);
        #1;
        check("rstfill_count", 32'(oq_d.size()), 32'(D));
        check_frame("rstfill", 0, img);

        // Reset in the middle of draining.
        rand_img();
        clear_q();
        send_frame(1'b0, D, 1'b0);
        wait_outs(101);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstdrain_valid", 32'(bus.oValid), 32'd0);
        check("rstdrain_ready", 32'(bus.oReady), 32'd1);
        check("rstdrain_tiles", 32'(bus.oTile_cnt), 32'd0);
        sz = oq_d.size();
        repeat (600) @(posedge clk);
        #1;
        check("rstdrain_no_more", 32'(oq_d.size()), 32'(sz));
        nfd = 0;
        foreach (oq_fd[i]) if (oq_fd[i]) nfd++;
        check("rstdrain_no_fd", 32'(nfd), 32'd0);

        // Frame after the aborted drain must start from tile 0 pixel 0.
        rand_img();
        clear_q();
        send_frame(1'b0, D, 1'b0);
        wait_outs(D);
        check_frame("post_rst", 0, img);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tile_to_raster.md
# tile_to_raster

Tile-order to raster-order pixel reassembler. Accepts a pixel stream arriving tile by tile: tiles left-to-right, then top-to-bottom; inside each tile, row-major. It stores each pixel at its raster address in an internal dual-port frame buffer. Once a full frame is captured, it streams the frame back out in raster order. It sits downstream of the tiled BRAM reader and the per-tile processing stages, and restores line order for display and DMA.

## Interface
- PIX_WIDTH, 8, pixel width in bits
- IMG_WIDTH, 32, frame width in pixels; must be a multiple of TILE_WIDTH
- IMG_HEIGHT, 16, frame height in pixels; must be a multiple of TILE_HEIGHT
- TILE_WIDTH, 16, tile width in pixels
- TILE_HEIGHT, 16, tile height in pixels
- Derived values:
  - NUM_TILES_X = IMG_WIDTH/TILE_WIDTH
  - NUM_TILES_Y = IMG_HEIGHT/TILE_HEIGHT
  - DEPTH = IMG_WIDTH*IMG_HEIGHT
  - AW = $clog2(DEPTH)
- iClk  in  1  single clock, rising edge
- iRst  in  1  synchronous active-low reset
- iValid  in  1  input pixel valid
- iData  in  PIX_WIDTH  input pixel, in tile order
- oReady  out  1  block accepts input; a pixel transfers on iValid && oReady
- oValid  out  1  output pixel valid
- oData  out  PIX_WIDTH  output pixel, in raster order
- oLine_end  out  1  high with the last pixel of each raster row
- oFrame_done  out  1  one-cycle pulse with the last pixel of the frame
- oTile_cnt  out  11  tiles fully received in the current frame

## Operation
- State machine states: FILL, DRAIN.
  - FILL → DRAIN when the last pixel of the last tile is accepted.
  - DRAIN → FILL after the last raster read address has been issued and its data has been presented.
- FILL:
  - oReady=1.
  - Counters: col (0..TILE_WIDTH-1), row (0..TILE_HEIGHT-1), tx (0..NUM_TILES_X-1), ty (0..NUM_TILES_Y-1).
  - Counters advance only on an accepted pixel: col is innermost, then row, then tx, then ty.
  - Write address = (ty*TILE_HEIGHT + row)*IMG_WIDTH + tx*TILE_WIDTH + col.
  - The address is computed combinationally from the current counters and written in the same cycle the pixel is accepted.
  - The address is evaluated at AW bits and never exceeds DEPTH-1.
  - oTile_cnt increments when the pixel at col=TILE_WIDTH-1, row=TILE_HEIGHT-1 is accepted.
- DRAIN:
  - oReady=0; iValid is ignored.
  - A read address counter issues 0..DEPTH-1, one address per cycle with no stalls.
  - The RAM read is registered with 1-cycle latency; oValid/oData follow the issued address by exactly one cycle.
  - oLine_end=1 when the presented pixel is at raster x = IMG_WIDTH-1.
  - oFrame_done=1 with raster address DEPTH-1.
  - oTile_cnt clears to 0 in the cycle FILL is re-entered.
- Frame buffer:
  - Inferred simple dual-port RAM of DEPTH × PIX_WIDTH: write port used in FILL, read port used in DRAIN.
  - No read-during-write case exists, because the two states are exclusive.
  - Contents are not cleared by reset.
- The block runs frames back to back with no IDLE state; it returns to FILL after every frame.

## Timing
- Reset values (iRst=0 sampled on the rising edge):
  - state=FILL, all counters 0.
  - oReady=1 from the first cycle after reset.
  - oValid=0, oData=0, oLine_end=0, oFrame_done=0, oTile_cnt=0.
- Reset mid-operation, in FILL or DRAIN: the partial frame is discarded, no further output is produced, and the next accepted pixel is tile 0 pixel 0.
- Fill, with a continuous iValid: DEPTH cycles.
- FILL → DRAIN transition:
  - oReady drops in the cycle after the final pixel is accepted.
  - The first read address is issued in that same cycle.
  - The first oValid appears one cycle later.
- Drain:
  - oValid is high for exactly DEPTH consecutive cycles.
  - oReady returns to 1 in the cycle after oFrame_done.
  - Frame turnaround (last pixel in → first pixel out) is 2 cycles.
- Input gaps: iValid may drop at any cycle in FILL; counters hold and nothing is written.
- Boundary cases:
  - When tx wraps to 0, ty increments.
  - When ty wraps at NUM_TILES_Y-1, the FILL→DRAIN transition occurs in the same cycle.
  - oTile_cnt reaches NUM_TILES_X*NUM_TILES_Y just before DRAIN.

## Test plan
- Defaults (32×16, 2 tiles), continuous iValid, each pixel value = its raster address mod 256:
  - oData must be 0,1,…,255,0,…,255 in raster order, 512 consecutive oValid cycles.
  - oLine_end must be high at outputs 31, 63, …, 511.
  - oFrame_done must be high only at output 511.
- Same frame with iValid toggling 1,0,1,0:
  - Output is identical to the continuous case.
  - oTile_cnt reads 1 after input pixel 255 and 2 after input pixel 511.
  - No write occurs on iValid=0 cycles.
- iValid held high during DRAIN with junk data 0xFF:
  - oReady=0 throughout DRAIN.
  - Buffer contents and output are unaffected.
  - The next frame starts at tile 0 pixel 0.
- Two back-to-back frames with patterns A and B:
  - Frame B's first pixel is accepted 1 cycle after frame A's oFrame_done.
  - Frame B output equals pattern B exactly.
- iRst asserted after 300 input pixels, then a full frame:
  - After reset, oReady=1, oTile_cnt=0, oValid=0.
  - The output contains only the post-reset frame.
- iRst asserted mid-DRAIN, after output 100:
  - oValid=0 from the cycle after reset.
  - state=FILL with all counters at 0.
  - oFrame_done never pulses for the aborted frame.
